// File: rtl/i2s_reader_buffer_ctrl_pkg.sv
// Shared encodings and helpers for the I2S reader ping-pong buffer scheduler.
package i2s_reader_defines;

  localparam logic [1:0] BUF_EMPTY  = 2'd0;
  localparam logic [1:0] BUF_ACTIVE = 2'd1;
  localparam logic [1:0] BUF_DRAIN  = 2'd2;
  localparam logic [1:0] BUF_FULL   = 2'd3;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_RUN  = 2'd1;
  localparam logic [1:0] CTRL_STOP = 2'd2;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int ENTRY_W        = 65;

  typedef struct packed {
    logic        tag;
    logic [31:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  // Byte address of a word slot; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [23:0] offset);
    return base + {6'd0, offset, 2'd0};
  endfunction

endpackage

// File: rtl/i2s_reader_skid_fifo.sv
// Synchronous skid FIFO between PHY word strobes and the memory write port.
module i2s_reader_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_o;
  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign head_o    = mem_q[rd_ptr_q];

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_reader_buffer_ctrl.sv
// Ping-pong buffer scheduler: offers buffers to the I2S PHY, turns strobes into
// addressed memory writes, and retires filled buffers to software.
module i2s_reader_buffer_ctrl
  import i2s_reader_defines::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [23:0]          i_buf_size,
  input  logic [31:0]          i_base_addr0,
  input  logic [31:0]          i_base_addr1,
  input  logic [1:0]           i_buf_release,
  output logic [23:0]          o_wfifo_size,
  output logic [1:0]           o_wfifo_ready,
  input  logic [1:0]           i_wfifo_activate,
  input  logic                 i_wfifo_strobe,
  input  logic [31:0]          i_wfifo_data,
  output logic                 o_mem_we,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_data,
  input  logic                 i_mem_ack,
  output logic [1:0]           o_buf_full,
  output logic                 o_irq,
  output logic [CNT_WIDTH-1:0] o_drop_count,
  output logic                 o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                ctrl_q, ctrl_d;
  logic [1:0][1:0]           buf_st_q, buf_st_d;
  logic                      next_buf_q, next_buf_d;
  logic [1:0][23:0]          offset_q, offset_d;
  logic [1:0][PW-1:0]        pend_q, pend_d;
  logic [1:0]                act_prev_q;
  logic [1:0]                ready_q, ready_d;
  logic                      irq_q, irq_d;
  logic [CNT_WIDTH-1:0]      drop_q, drop_d;

  fifo_entry_t push_entry_s, head_s;
  logic        fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic        one_act_s, act_idx_s, in_range_s, push_s, drop_s;
  logic [1:0]  push_hit_s, pop_hit_s, claim_s;

  assign fifo_pop_s = ~fifo_empty_s & i_mem_ack;
  assign one_act_s  = i_wfifo_activate[0] ^ i_wfifo_activate[1];
  assign act_idx_s  = i_wfifo_activate[1];
  assign in_range_s = offset_q[act_idx_s] < i_buf_size;
  assign push_s     = i_wfifo_strobe & one_act_s & in_range_s & (~fifo_full_s | fifo_pop_s);
  assign drop_s     = i_wfifo_strobe & ~push_s;
  assign push_hit_s = push_s ? (act_idx_s ? 2'b10 : 2'b01) : 2'b00;
  assign pop_hit_s  = fifo_pop_s ? (head_s.tag ? 2'b10 : 2'b01) : 2'b00;

  assign push_entry_s.tag  = act_idx_s;
  assign push_entry_s.addr = word_addr(act_idx_s ? i_base_addr1 : i_base_addr0, offset_q[act_idx_s]);
  assign push_entry_s.data = i_wfifo_data;

  // The PHY may only claim the buffer currently being offered.
  assign claim_s[0] = (ctrl_q == CTRL_RUN) & ~next_buf_q & ready_q[0] & i_wfifo_activate[0];
  assign claim_s[1] = (ctrl_q == CTRL_RUN) &  next_buf_q & ready_q[1] & i_wfifo_activate[1];

  i2s_reader_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_skid_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (fifo_pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Next-state logic for control FSM, buffer states, offsets and counters.
  always_comb begin
    ctrl_d     = ctrl_q;
    buf_st_d   = buf_st_q;
    next_buf_d = next_buf_q;
    offset_d   = offset_q;
    pend_d     = pend_q;
    ready_d    = 2'b00;
    irq_d      = 1'b0;
    drop_d     = drop_q;

    if (drop_s && (drop_q != {CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end

    for (int b = 0; b < 2; b++) begin
      pend_d[b] = pend_q[b] + {{(PW-1){1'b0}}, push_hit_s[b]} - {{(PW-1){1'b0}}, pop_hit_s[b]};
      if (push_hit_s[b]) begin
        offset_d[b] = offset_q[b] + 24'd1;
      end else begin
        offset_d[b] = offset_q[b];
      end
      case (buf_st_q[b])
        BUF_EMPTY: begin
          if (claim_s[b]) begin
            buf_st_d[b] = BUF_ACTIVE;
            offset_d[b] = 24'd0;
            next_buf_d  = ~next_buf_q;
          end else begin
            buf_st_d[b] = BUF_EMPTY;
          end
        end
        BUF_ACTIVE: begin
          if (act_prev_q[b] && !i_wfifo_activate[b]) begin
            buf_st_d[b] = BUF_DRAIN;
          end else begin
            buf_st_d[b] = BUF_ACTIVE;
          end
        end
        BUF_DRAIN: begin
          // Completion only counts while running; a stopped buffer is discarded.
          if ((ctrl_q == CTRL_RUN) && (pend_d[b] == '0)) begin
            buf_st_d[b] = BUF_FULL;
            irq_d       = 1'b1;
          end else begin
            buf_st_d[b] = BUF_DRAIN;
          end
        end
        BUF_FULL: begin
          if (i_buf_release[b]) begin
            buf_st_d[b] = BUF_EMPTY;
          end else begin
            buf_st_d[b] = BUF_FULL;
          end
        end
        default: buf_st_d[b] = BUF_EMPTY;
      endcase
    end

    if ((ctrl_q == CTRL_RUN) && i_enable && (buf_st_q[next_buf_q] == BUF_EMPTY) && (claim_s == 2'b00)) begin
      ready_d[next_buf_q] = 1'b1;
    end else begin
      ready_d = 2'b00;
    end

    case (ctrl_q)
      CTRL_IDLE: begin
        if (i_enable && (i_buf_size != 24'd0)) begin
          ctrl_d = CTRL_RUN;
        end else begin
          ctrl_d = CTRL_IDLE;
        end
      end
      CTRL_RUN: begin
        if (!i_enable) begin
          ctrl_d = CTRL_STOP;
        end else begin
          ctrl_d = CTRL_RUN;
        end
      end
      CTRL_STOP: begin
        if (fifo_empty_s && (i_wfifo_activate == 2'b00)) begin
          ctrl_d     = CTRL_IDLE;
          next_buf_d = 1'b0;
          for (int b = 0; b < 2; b++) begin
            if (buf_st_d[b] != BUF_FULL) begin
              buf_st_d[b] = BUF_EMPTY;
            end else begin
              buf_st_d[b] = BUF_FULL;
            end
          end
        end else begin
          ctrl_d = CTRL_STOP;
        end
      end
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_IDLE;
      buf_st_q   <= {BUF_EMPTY, BUF_EMPTY};
      next_buf_q <= 1'b0;
      offset_q   <= '0;
      pend_q     <= '0;
      act_prev_q <= 2'b00;
      ready_q    <= 2'b00;
      irq_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      buf_st_q   <= buf_st_d;
      next_buf_q <= next_buf_d;
      offset_q   <= offset_d;
      pend_q     <= pend_d;
      act_prev_q <= i_wfifo_activate;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
      drop_q     <= drop_d;
    end
  end

  assign o_wfifo_size  = i_buf_size;
  assign o_wfifo_ready = ready_q;
  assign o_mem_we      = ~fifo_empty_s;
  assign o_mem_addr    = fifo_empty_s ? 32'd0 : head_s.addr;
  assign o_mem_data    = fifo_empty_s ? 32'd0 : head_s.data;
  assign o_buf_full[0] = (buf_st_q[0] == BUF_FULL);
  assign o_buf_full[1] = (buf_st_q[1] == BUF_FULL);
  assign o_irq         = irq_q;
  assign o_drop_count  = drop_q;
  assign o_busy        = (ctrl_q != CTRL_IDLE);

endmodule
